// File: rtl/disp_pkg.sv
// Shared types, geometry record and colour-bar constants for display_line_scanout.
package disp_pkg;

    localparam int unsigned PIX_W     = 24;
    localparam int unsigned MAX_PIX   = 110;
    localparam int unsigned LINE_BITS = PIX_W * MAX_PIX;
    localparam int unsigned LINE_LAT  = 1;
    localparam int unsigned CNT_W     = 10;
    localparam int unsigned HCNT_W    = CNT_W + 1;
    localparam int unsigned IDX_W     = $clog2(MAX_PIX);
    localparam int unsigned WIND_W    = 16;
    localparam int unsigned BAR_W     = 3;

    typedef logic [PIX_W-1:0]   pixel_t;
    typedef logic [0:LINE_BITS-1] line_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ACTIVE,
        ST_HBLANK,
        ST_VBLANK
    } state_t;

    // Geometry latched at frame start
    typedef struct packed {
        logic [CNT_W-1:0] hb;
        logic [CNT_W-1:0] vb;
        logic [CNT_W-1:0] aip;
        logic [CNT_W-1:0] ail;
    } geom_t;

    localparam pixel_t BAR_WHITE   = 24'hFFFFFF;
    localparam pixel_t BAR_YELLOW  = 24'hFFFF00;
    localparam pixel_t BAR_CYAN    = 24'h00FFFF;
    localparam pixel_t BAR_GREEN   = 24'h00FF00;
    localparam pixel_t BAR_MAGENTA = 24'hFF00FF;
    localparam pixel_t BAR_RED     = 24'hFF0000;
    localparam pixel_t BAR_BLUE    = 24'h0000FF;
    localparam pixel_t BAR_BLACK   = 24'h000000;

    function automatic pixel_t bar_colour(input logic [BAR_W-1:0] bar);
        case (bar)
            3'd0:    return BAR_WHITE;
            3'd1:    return BAR_YELLOW;
            3'd2:    return BAR_CYAN;
            3'd3:    return BAR_GREEN;
            3'd4:    return BAR_MAGENTA;
            3'd5:    return BAR_RED;
            3'd6:    return BAR_BLUE;
            default: return BAR_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/display_line_scanout_if.sv
// Line fetch bus between the frame datapath (slave) and the scanout (master).
interface display_line_scanout_if;
    import disp_pkg::*;

    logic              readFrame;
    logic [WIND_W-1:0] FrameWInd;
    line_t             FrameDataOut;

    modport master (output readFrame, output FrameWInd, input FrameDataOut);
    modport slave  (input readFrame, input FrameWInd, output FrameDataOut);
endinterface

// File: rtl/display_line_scanout_line_serializer.sv
// Holds one captured line word and presents the pixel addressed by idx.
module line_serializer
    import disp_pkg::*;
(
    input  logic             clk,
    input  logic             cap,
    input  line_t            line_in,
    input  logic [IDX_W-1:0] idx,
    output pixel_t           pixel_c
);

    pixel_t pix_q [MAX_PIX];

    // Lowest bit index of each pixel slice is its MSB
    always_ff @(posedge clk) begin
        if (cap) begin
            for (int unsigned k = 0; k < MAX_PIX; k++) begin
                pix_q[k] <= line_in[k*PIX_W +: PIX_W];
            end
        end
    end

    always_comb begin
        pixel_c = '0;
        if (32'(idx) < MAX_PIX) pixel_c = pix_q[idx];
    end

endmodule

// File: rtl/display_line_scanout.sv
// Fetches frame lines by index and serializes them to a pixel stream with
// de/hsync/vsync. Optional colour-bar source enabled by DISP_TESTPAT_EN.
module display_line_scanout
    import disp_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [CNT_W-1:0]       HBOut_PD,
    input  logic [CNT_W-1:0]       VBOut_PD,
    input  logic [CNT_W-1:0]       AIPOut_PD,
    input  logic [CNT_W-1:0]       AILOut_PD,
`ifdef DISP_TESTPAT_EN
    input  logic                   test_pat,
`endif
    display_line_scanout_if.master line_bus,
    output pixel_t                 pix_data,
    output logic                   de,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   frame_done,
    output logic                   cfg_err
);

    state_t            state, state_n;
    geom_t             geom_q, geom_c;
    logic [HCNT_W-1:0] hcnt, hcnt_n;
    logic [CNT_W-1:0]  line_idx, line_n, vcnt, vcnt_n;
    logic [HCNT_W-1:0] aip_last_c, hb_last_c, vline_last_c;
    logic              start_c, latch_c, bad_c, cap_c, line_end_c, frame_end_c;
    logic              rd_c, de_c, hsync_c, vsync_c, done_d;
    pixel_t            ser_pixel_c, pix_c;

    always_comb begin
        geom_c.hb  = HBOut_PD;
        geom_c.vb  = VBOut_PD;
        geom_c.aip = (AIPOut_PD > CNT_W'(MAX_PIX)) ? CNT_W'(MAX_PIX) : AIPOut_PD;
        geom_c.ail = AILOut_PD;
    end

    assign aip_last_c   = HCNT_W'(geom_q.aip) - HCNT_W'(1);
    assign hb_last_c    = HCNT_W'(geom_q.hb) - HCNT_W'(1);
    assign vline_last_c = HCNT_W'(geom_q.aip) + HCNT_W'(geom_q.hb) - HCNT_W'(1);

    line_serializer u_ser (
        .clk     (clk),
        .cap     (cap_c),
        .line_in (line_bus.FrameDataOut),
        .idx     (hcnt[IDX_W-1:0]),
        .pixel_c (ser_pixel_c)
    );

    // Next-state and counter logic; frame end may restart directly into FETCH
    always_comb begin
        state_n     = state;
        hcnt_n      = hcnt;
        line_n      = line_idx;
        vcnt_n      = vcnt;
        start_c     = 1'b0;
        latch_c     = 1'b0;
        bad_c       = 1'b0;
        cap_c       = 1'b0;
        line_end_c  = 1'b0;
        frame_end_c = 1'b0;
        case (state)
            ST_IDLE: start_c = enable;
            ST_FETCH: begin
                if (hcnt == HCNT_W'(LINE_LAT)) begin
                    cap_c   = 1'b1;
                    hcnt_n  = '0;
                    state_n = ST_ACTIVE;
                end else begin
                    hcnt_n = hcnt + HCNT_W'(1);
                end
            end
            ST_ACTIVE: begin
                if (hcnt == aip_last_c) begin
                    hcnt_n = '0;
                    if (geom_q.hb == '0) line_end_c = 1'b1;
                    else                 state_n    = ST_HBLANK;
                end else begin
                    hcnt_n = hcnt + HCNT_W'(1);
                end
            end
            ST_HBLANK: begin
                if (hcnt == hb_last_c) line_end_c = 1'b1;
                else                   hcnt_n     = hcnt + HCNT_W'(1);
            end
            ST_VBLANK: begin
                if (hcnt == vline_last_c) begin
                    hcnt_n = '0;
                    if (vcnt == geom_q.vb - CNT_W'(1)) frame_end_c = 1'b1;
                    else                               vcnt_n      = vcnt + CNT_W'(1);
                end else begin
                    hcnt_n = hcnt + HCNT_W'(1);
                end
            end
            default: state_n = ST_IDLE;
        endcase

        if (line_end_c) begin
            hcnt_n = '0;
            if (HCNT_W'(line_idx) + HCNT_W'(1) < HCNT_W'(geom_q.ail)) begin
                line_n  = line_idx + CNT_W'(1);
                state_n = ST_FETCH;
            end else if (geom_q.vb != '0) begin
                vcnt_n  = '0;
                state_n = ST_VBLANK;
            end else begin
                frame_end_c = 1'b1;
            end
        end

        if (frame_end_c) begin
            hcnt_n  = '0;
            vcnt_n  = '0;
            line_n  = '0;
            state_n = ST_IDLE;
            start_c = enable;
        end

        if (start_c) begin
            latch_c = 1'b1;
            if (geom_c.aip == '0 || geom_c.ail == '0) begin
                bad_c   = 1'b1;
                state_n = ST_IDLE;
            end else begin
                hcnt_n  = '0;
                line_n  = '0;
                state_n = ST_FETCH;
            end
        end

        rd_c    = (state_n == ST_FETCH) && (state != ST_FETCH);
        de_c    = (state == ST_ACTIVE);
        hsync_c = (state == ST_HBLANK) ||
                  ((state == ST_VBLANK) && (hcnt >= HCNT_W'(geom_q.aip)));
        vsync_c = (state == ST_VBLANK);
    end

`ifdef DISP_TESTPAT_EN
    logic             tp_q;
    logic [BAR_W-1:0] bar_q;
    logic [CNT_W-1:0] sub_q, bar_w_q;

    // Colour-bar position tracked incrementally to avoid a divider
    always_ff @(posedge clk) begin
        if (reset) begin
            tp_q    <= 1'b0;
            bar_q   <= '0;
            sub_q   <= '0;
            bar_w_q <= CNT_W'(1);
        end else begin
            if (latch_c) begin
                tp_q    <= test_pat;
                bar_w_q <= ((geom_c.aip >> 3) == '0) ? CNT_W'(1) : (geom_c.aip >> 3);
            end
            if (state_n == ST_ACTIVE && state != ST_ACTIVE) begin
                bar_q <= '0;
                sub_q <= '0;
            end else if (state == ST_ACTIVE) begin
                if (sub_q == bar_w_q - CNT_W'(1)) begin
                    sub_q <= '0;
                    if (bar_q != BAR_W'(7)) bar_q <= bar_q + BAR_W'(1);
                end else begin
                    sub_q <= sub_q + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        pix_c = '0;
        if (de_c) pix_c = tp_q ? bar_colour(bar_q) : ser_pixel_c;
    end
`else
    always_comb begin
        pix_c = '0;
        if (de_c) pix_c = ser_pixel_c;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= ST_IDLE;
            hcnt               <= '0;
            line_idx           <= '0;
            vcnt               <= '0;
            geom_q             <= '0;
            line_bus.readFrame <= 1'b0;
            line_bus.FrameWInd <= '0;
            pix_data           <= '0;
            de                 <= 1'b0;
            hsync              <= 1'b0;
            vsync              <= 1'b0;
            done_d             <= 1'b0;
            frame_done         <= 1'b0;
            cfg_err            <= 1'b0;
        end else begin
            state              <= state_n;
            hcnt               <= hcnt_n;
            line_idx           <= line_n;
            vcnt               <= vcnt_n;
            if (latch_c) geom_q <= geom_c;
            if (bad_c)   cfg_err <= 1'b1;
            line_bus.readFrame <= rd_c;
            if (rd_c) line_bus.FrameWInd <= WIND_W'(line_n);
            pix_data           <= pix_c;
            de                 <= de_c;
            hsync              <= hsync_c;
            vsync              <= vsync_c;
            // frame_done lands on the cycle after the last pixel/blanking output
            done_d             <= frame_end_c;
            frame_done         <= done_d;
        end
    end

endmodule

// File: tb/tb_display_line_scanout.sv
// Directed self-checking bench for display_line_scanout with a one-cycle-latency line source.
module tb_display_line_scanout;
    import disp_pkg::*;

    logic       clk = 1'b0;
    logic       reset, enable;
    logic [9:0] hb, vb, aip, ail;
`ifdef DISP_TESTPAT_EN
    logic       test_pat;
`endif
    pixel_t     pix_data;
    logic       de, hsync, vsync, frame_done, cfg_err;

    display_line_scanout_if bus();

    display_line_scanout dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .HBOut_PD   (hb),
        .VBOut_PD   (vb),
        .AIPOut_PD  (aip),
        .AILOut_PD  (ail),
`ifdef DISP_TESTPAT_EN
        .test_pat   (test_pat),
`endif
        .line_bus   (bus),
        .pix_data   (pix_data),
        .de         (de),
        .hsync      (hsync),
        .vsync      (vsync),
        .frame_done (frame_done),
        .cfg_err    (cfg_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    function automatic pixel_t exp_pix(input int unsigned ln, input int unsigned p);
        logic [7:0] a, b;
        a = 8'(ln);
        b = 8'(p);
        return {a, b, 8'hA5};
    endfunction

    function automatic line_t make_line(input int unsigned ln);
        line_t w;
        for (int unsigned p = 0; p < MAX_PIX; p++) w[p*PIX_W +: PIX_W] = exp_pix(ln, p);
        return w;
    endfunction

    function automatic pixel_t exp_bar(input int unsigned p, input int unsigned aipv);
        int unsigned bw, b;
        bw = aipv / 8;
        if (bw == 0) bw = 1;
        b = p / bw;
        if (b > 7) b = 7;
        case (b)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    // Line source: data for the requested index is valid one cycle after readFrame
    always @(posedge clk) if (bus.readFrame) bus.FrameDataOut <= make_line(32'(bus.FrameWInd));

    int rf_cnt, wind_bad, de_cnt, pix_bad, idle_bad, hs_act, hs_vb, vs_cnt, fd_cnt;
    int first_rf_n, second_rf_n, first_de_n, fd_n, first_wind;
    bit timeout;

    // Runs one frame, dropping enable after the first request, and gathers statistics
    task automatic run_frame(input int unsigned aip_eff, input bit tp, input int budget);
        int n;
        pixel_t e;
        rf_cnt = 0; wind_bad = 0; de_cnt = 0; pix_bad = 0; idle_bad = 0;
        hs_act = 0; hs_vb = 0; vs_cnt = 0; fd_cnt = 0;
        first_rf_n = -1; second_rf_n = -1; first_de_n = -1; fd_n = -1; first_wind = -1;
        timeout = 1'b0;
        n = 0;
        while (1) begin
            @(negedge clk);
            n++;
            if (bus.readFrame) begin
                if (rf_cnt == 0) begin
                    first_rf_n = n;
                    first_wind = int'(bus.FrameWInd);
                    enable = 1'b0;
                end
                if (rf_cnt == 1) second_rf_n = n;
                if (int'(bus.FrameWInd) != rf_cnt) wind_bad++;
                rf_cnt++;
            end
            if (de) begin
                if (de_cnt == 0) first_de_n = n;
                e = tp ? exp_bar(de_cnt % aip_eff, aip_eff) : exp_pix(de_cnt / aip_eff, de_cnt % aip_eff);
                if (pix_data !== e) pix_bad++;
                de_cnt++;
            end else if (pix_data !== '0) idle_bad++;
            if (hsync) begin
                if (vsync) hs_vb++;
                else       hs_act++;
            end
            if (vsync) vs_cnt++;
            if (frame_done) begin
                fd_cnt++;
                if (fd_cnt == 1) fd_n = n;
            end
            if (fd_cnt > 0 && n >= fd_n + 4) break;
            if (n >= budget) begin
                timeout = 1'b1;
                break;
            end
        end
        checks++;
        if (timeout) begin errors++; $display("FAIL frame_timeout: no frame_done within %0d cycles", budget); end
    endtask

    task automatic set_geom(input int h, input int v, input int p, input int l);
        hb = 10'(h); vb = 10'(v); aip = 10'(p); ail = 10'(l);
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0;
        set_geom(0, 0, 0, 0);
`ifdef DISP_TESTPAT_EN
        test_pat = 1'b0;
`endif
        repeat (3) @(negedge clk);
        checks++; if (bus.readFrame !== 1'b0) begin errors++; $display("FAIL rst_readFrame: got %b want 0", bus.readFrame); end
        checks++; if (bus.FrameWInd !== 16'd0) begin errors++; $display("FAIL rst_FrameWInd: got %0d want 0", bus.FrameWInd); end
        checks++; if (pix_data !== 24'd0) begin errors++; $display("FAIL rst_pix_data: got %h want 0", pix_data); end
        checks++; if (de !== 1'b0) begin errors++; $display("FAIL rst_de: got %b want 0", de); end
        checks++; if (hsync !== 1'b0) begin errors++; $display("FAIL rst_hsync: got %b want 0", hsync); end
        checks++; if (vsync !== 1'b0) begin errors++; $display("FAIL rst_vsync: got %b want 0", vsync); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_frame_done: got %b want 0", frame_done); end
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL rst_cfg_err: got %b want 0", cfg_err); end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.readFrame !== 1'b0) begin errors++; $display("FAIL idle_no_request: got %b want 0", bus.readFrame); end
    endtask

    task automatic test_full_frame();
        set_geom(10, 10, 100, 100);
        enable = 1'b1;
        run_frame(100, 1'b0, 14000);
        checks++; if (rf_cnt != 100) begin errors++; $display("FAIL full_requests: got %0d want 100", rf_cnt); end
        checks++; if (wind_bad != 0) begin errors++; $display("FAIL full_wind_order: got %0d bad want 0", wind_bad); end
        checks++; if (de_cnt != 10000) begin errors++; $display("FAIL full_de_count: got %0d want 10000", de_cnt); end
        checks++; if (pix_bad != 0) begin errors++; $display("FAIL full_pixels: got %0d bad want 0", pix_bad); end
        checks++; if (idle_bad != 0) begin errors++; $display("FAIL full_blank_pix: got %0d nonzero want 0", idle_bad); end
        checks++; if (hs_act != 1000) begin errors++; $display("FAIL full_hsync_active: got %0d want 1000", hs_act); end
        checks++; if (hs_vb != 100) begin errors++; $display("FAIL full_hsync_vblank: got %0d want 100", hs_vb); end
        checks++; if (vs_cnt != 1100) begin errors++; $display("FAIL full_vsync: got %0d want 1100", vs_cnt); end
        checks++; if (fd_cnt != 1) begin errors++; $display("FAIL full_frame_done: got %0d want 1", fd_cnt); end
        checks++; if (first_de_n - first_rf_n != 3) begin errors++; $display("FAIL full_first_pixel_lat: got %0d want 3", first_de_n - first_rf_n); end
    endtask

    task automatic test_clamp();
        set_geom(2, 1, 120, 2);
        enable = 1'b1;
        run_frame(110, 1'b0, 1000);
        checks++; if (de_cnt != 220) begin errors++; $display("FAIL clamp_de_count: got %0d want 220", de_cnt); end
        checks++; if (pix_bad != 0) begin errors++; $display("FAIL clamp_pixels: got %0d bad want 0", pix_bad); end
        checks++; if (vs_cnt != 112) begin errors++; $display("FAIL clamp_vsync: got %0d want 112", vs_cnt); end
        checks++; if (hs_vb != 2 || hs_act != 4) begin errors++; $display("FAIL clamp_hsync: got %0d/%0d want 4/2", hs_act, hs_vb); end
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL clamp_cfg_err: got %b want 0", cfg_err); end
    endtask

    task automatic test_cfg_err();
        int rf;
        rf = 0;
        set_geom(3, 2, 5, 0);
        enable = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (bus.readFrame) rf++;
        end
        checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_err_set: got %b want 1", cfg_err); end
        checks++; if (rf != 0) begin errors++; $display("FAIL cfg_err_no_request: got %0d want 0", rf); end
        enable = 1'b0;
        set_geom(3, 2, 5, 4);
        repeat (3) @(negedge clk);
        checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_err_sticky: got %b want 1", cfg_err); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_err_clear: got %b want 0", cfg_err); end
    endtask

    task automatic test_back_to_back();
        set_geom(0, 0, 4, 2);
        enable = 1'b1;
        run_frame(4, 1'b0, 200);
        checks++; if (rf_cnt != 2 || wind_bad != 0) begin errors++; $display("FAIL b2b_requests: got %0d (%0d bad) want 2", rf_cnt, wind_bad); end
        checks++; if (second_rf_n - first_rf_n != 6) begin errors++; $display("FAIL b2b_line_period: got %0d want 6", second_rf_n - first_rf_n); end
        checks++; if (de_cnt != 8 || pix_bad != 0) begin errors++; $display("FAIL b2b_pixels: got %0d de (%0d bad) want 8", de_cnt, pix_bad); end
        checks++; if (hs_act + hs_vb + vs_cnt != 0) begin errors++; $display("FAIL b2b_no_sync: got %0d want 0", hs_act + hs_vb + vs_cnt); end
        checks++; if (fd_n - first_rf_n != 13) begin errors++; $display("FAIL b2b_frame_done_time: got %0d want 13", fd_n - first_rf_n); end
        checks++; if (fd_cnt != 1) begin errors++; $display("FAIL b2b_frame_done_count: got %0d want 1", fd_cnt); end
    endtask

    task automatic test_reset_mid_frame();
        int rf, n, fd;
        rf = 0; n = 0; fd = 0;
        set_geom(3, 2, 8, 6);
        enable = 1'b1;
        while (rf < 4 && n < 300) begin
            @(negedge clk);
            n++;
            if (bus.readFrame) rf++;
        end
        checks++; if (rf != 4) begin errors++; $display("FAIL mid_reach_line3: got %0d requests want 4", rf); end
        repeat (3) @(negedge clk);
        checks++; if (de !== 1'b1 || pix_data !== exp_pix(3, 0)) begin errors++; $display("FAIL mid_line3_active: got de=%b pix=%h want de=1 pix=%h", de, pix_data, exp_pix(3, 0)); end
        reset = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.readFrame, de, hsync, vsync, frame_done, cfg_err} !== 6'b0 || pix_data !== 24'd0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got rf=%b de=%b hs=%b vs=%b fd=%b ce=%b pix=%h want all 0",
                     bus.readFrame, de, hsync, vsync, frame_done, cfg_err, pix_data);
        end
        @(negedge clk);
        if (frame_done) fd++;
        reset = 1'b0;
        enable = 1'b1;
        run_frame(8, 1'b0, 1000);
        checks++; if (fd != 0) begin errors++; $display("FAIL mid_no_frame_done: got %0d want 0", fd); end
        checks++; if (first_wind != 0) begin errors++; $display("FAIL mid_restart_index: got %0d want 0", first_wind); end
        checks++; if (rf_cnt != 6 || de_cnt != 48 || pix_bad != 0) begin errors++; $display("FAIL mid_restart_frame: got rf=%0d de=%0d bad=%0d want 6/48/0", rf_cnt, de_cnt, pix_bad); end
    endtask

`ifdef DISP_TESTPAT_EN
    task automatic test_testpat();
        set_geom(2, 0, 16, 2);
        test_pat = 1'b1;
        enable = 1'b1;
        run_frame(16, 1'b1, 300);
        test_pat = 1'b0;
        checks++; if (de_cnt != 32) begin errors++; $display("FAIL tp_de_count: got %0d want 32", de_cnt); end
        checks++; if (pix_bad != 0) begin errors++; $display("FAIL tp_bars: got %0d bad want 0", pix_bad); end
    endtask
`endif

    initial begin
        test_reset();
        test_full_frame();
        test_clamp();
        test_cfg_err();
        test_back_to_back();
        test_reset_mid_frame();
`ifdef DISP_TESTPAT_EN
        test_testpat();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/display_line_scanout.md
Name: display_line_scanout

Overview:
- Downstream neighbour of DataPath. Consumes the line-wide frame word (FrameDataOut, 2640 bits = 110 pixels x 24 bit RGB) one line at a time.
- Requests lines by index, captures each line, and serializes it into a pixel stream with de/hsync/vsync.
- Uses the same blanking/active geometry registers as DataPath: HB, VB, AIP, AIL.
- Feeds the panel/output-file writer stage.

Parameters:
- PIX_W, 24, bits per pixel.
- MAX_PIX, 110, pixels held in one FrameDataOut word.
- LINE_BITS, 2640, width of line input; must equal PIX_W*MAX_PIX.
- LINE_LAT, 1, cycles from line_req to FrameDataOut valid.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- enable  in  1  start/continue scanout; sampled at frame boundaries only.
- HBOut_PD  in  10  horizontal blanking cycles per line.
- VBOut_PD  in  10  vertical blanking lines per frame.
- AIPOut_PD  in  10  active pixels per line.
- AILOut_PD  in  10  active lines per frame.
- FrameDataOut  in  LINE_BITS  line data, [0:LINE_BITS-1]; pixel k = bits [k*PIX_W : k*PIX_W+PIX_W-1], lowest index is MSB.
- readFrame  out  1  one-cycle line request.
- FrameWInd  out  16  line index for current request.
- pix_data  out  PIX_W  serialized pixel.
- de  out  1  pixel valid (active region).
- hsync  out  1  high during HBLANK cycles.
- vsync  out  1  high for every cycle of VBLANK lines.
- frame_done  out  1  one-cycle pulse after last VBLANK cycle.
- cfg_err  out  1  sticky: latched geometry illegal.

Behaviour:
- Reset: all outputs 0. State IDLE. Counters 0. Reset mid-frame aborts immediately; no frame_done.
- Config latch: in IDLE with enable=1, latch HB/VB/AIP/AIL.
  - AIP is clamped to MAX_PIX if larger.
  - AIP=0 or AIL=0 sets cfg_err, stays IDLE; cleared only by reset.
  - Geometry inputs are ignored mid-frame.
- States and transitions:
  - IDLE -> FETCH.
  - FETCH: readFrame=1 for first cycle with FrameWInd=line; wait LINE_LAT cycles; next cycle captures FrameDataOut into line register; -> ACTIVE. Duration LINE_LAT+1 cycles. de/hsync/vsync=0.
  - ACTIVE: AIP cycles; de=1, pix_data=pixel[pcnt], pcnt 0..AIP-1; -> HBLANK. If HB=0, go directly to next-line decision.
  - HBLANK: HB cycles; hsync=1, pix_data=0.
  - Next-line decision: if line<AIL-1, line++ -> FETCH. Else -> VBLANK, or frame-end if VB=0.
  - VBLANK: VB lines of (AIP+HB) cycles each; vsync=1, hsync=1 during the last HB cycles of each line; no readFrame.
  - Frame end: frame_done=1 for one cycle, line=0. enable=1 -> relatch config, FETCH. enable=0 -> IDLE.
- pix_data is registered; de and pix_data align in the same cycle. First pixel appears LINE_LAT+2 cycles after entering FETCH.
- Counters are 10-bit; FrameWInd is zero-extended line index. No wrap is possible because AIL<=1023.
- enable deassert mid-frame has no effect until frame end.

Optional Feature:
- DISP_TESTPAT_EN
  - Defined: adds input test_pat (1 bit, sampled at frame start). When set, FETCH still runs but captured data is ignored. pix_data = colour bars: bar = pcnt/ (AIP/8 rounded down, min 1), capped at 7. Bar colours 0..7 = FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
  - Undefined: port absent; pix_data always from FrameDataOut.

Decomposition:
- Shared package disp_pkg:
  - state encoding (IDLE, FETCH, ACTIVE, HBLANK, VBLANK)
  - PIX_W/MAX_PIX defaults
  - colour-bar constants
- Sub-module line_serializer: captures the line word and muxes pixel[pcnt]. Top keeps FSM and counters.

Test Plan:
- HB=10, VB=10, AIP=100, AIL=100, enable=1, FrameDataOut line k filled with pixel value {k[7:0],pix[7:0],8'hA5} -> exactly 100 readFrame pulses with FrameWInd 0..99; 10000 de cycles in order; 10 hsync cycles per line; 10x110 vsync cycles; one frame_done.
- AIP=120 -> clamped: 110 de cycles per line; cfg_err=0.
- AIL=0 with enable=1 -> cfg_err=1, no readFrame, stays IDLE; reset clears.
- HB=0, VB=0, AIP=4, AIL=2 -> lines back-to-back through FETCH, no hsync/vsync; frame_done 2*(LINE_LAT+1+4)+1 cycles after start.
- reset asserted during line 3 ACTIVE -> next cycle all outputs 0; after release with enable=1, first readFrame has FrameWInd=0.
- DISP_TESTPAT_EN, test_pat=1, AIP=16 -> pix_data sequence FFFFFF x2, FFFF00 x2, ... 000000 x2 per line.
